// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding, bus widths and the parity helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_FRAME_CYCLES = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Even parity when odd = 0, odd parity when odd = 1.
  function automatic logic uart_parity(input logic [UART_DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: first set request after 'last', wrapping modulo NREQ.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to accept the pick.
// Ports: req (request vector), last (previous grant index), gnt (one-hot pick),
//        idx (pick index, equals last when nothing requested), any (a request was found).
module uart_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] cand;

  // Walk the candidates last+1, last+2, ... last+NREQ; the last step revisits
  // 'last' itself so a lone requester that was just served can be served again.
  always_comb begin
    gnt  = '0;
    idx  = last;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte requesters.
// Latency: 1 cycle from req_valid sampled in IDLE to tx_send; frames spaced >= FRAME_CYCLES+1 clocks.
// Backpressure: req_ready pulses once per accepted byte; no grant while a frame is in flight or en = 0.
// Ports: clk, rst_n (sync, active low), en, req_valid/req_data (packed bytes, requester i at
//        [i*DATA_W +: DATA_W]), req_ready (one-hot accept), tx_data/tx_send/tx_parity/tx_stop
//        to the transmitter, busy (SEND or WAIT), grant_id (last granted requester).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int DATA_W       = UART_DATA_W,
  parameter int FRAME_CYCLES = UART_FRAME_CYCLES,
  parameter int PARITY_ODD   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_send,
  output logic                     tx_parity,
  output logic                     tx_stop,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(FRAME_CYCLES);

  if (FRAME_CYCLES < 2) begin : g_bad_frame
    $error("uart_tx_arbiter: FRAME_CYCLES must be at least 2");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("uart_tx_arbiter: NREQ must be in 2..8");
  end
  if (DATA_W != UART_DATA_W) begin : g_bad_width
    $error("uart_tx_arbiter: DATA_W must match the transmitter bus width");
  end

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [NREQ-1:0]   pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [DATA_W-1:0] pick_byte;

  uart_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req  (req_valid),
    .last (grant_id),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign pick_byte = req_data[int'(pick_idx)*DATA_W +: DATA_W];

  // SEND lasts one cycle, then WAIT counts FRAME_CYCLES-2 down to 0 inclusive,
  // so SEND+WAIT spans exactly FRAME_CYCLES clocks. The transmitter has no busy
  // output, so this count is the only thing keeping frames from overlapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= '0;
      tx_send   <= 1'b0;
      tx_data   <= '0;
      tx_parity <= 1'b0;
      tx_stop   <= 1'b1;
      busy      <= 1'b0;
      grant_id  <= IW'(NREQ-1);
      cnt       <= '0;
    end else begin
      tx_stop <= 1'b1;
      case (state)
        IDLE: begin
          if (en && pick_any) begin
            state     <= SEND;
            tx_data   <= pick_byte;
            tx_parity <= uart_parity(pick_byte, PARITY_ODD != 0);
            grant_id  <= pick_idx;
            req_ready <= pick_gnt;
            tx_send   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SEND: begin
          req_ready <= '0;
          tx_send   <= 1'b0;
          cnt       <= CW'(FRAME_CYCLES-2);
          state     <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= '0;
          tx_send   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: frame-timer reference model compared every cycle,
// directed scenarios with literal expectations, then randomized requesters.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int FRAME = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_send, tx_parity, tx_stop, busy;
  logic [1:0]  grant_id;

  logic        o_en;
  logic [3:0]  o_valid;
  logic [31:0] o_data;
  logic [3:0]  o_ready;
  logic [7:0]  o_txd;
  logic        o_send, o_par, o_stop, o_busy;
  logic [1:0]  o_gid;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(8), .FRAME_CYCLES(FRAME), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_send(tx_send), .tx_parity(tx_parity),
    .tx_stop(tx_stop), .busy(busy), .grant_id(grant_id)
  );

  uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(8), .FRAME_CYCLES(FRAME), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .en(o_en), .req_valid(o_valid), .req_data(o_data),
    .req_ready(o_ready), .tx_data(o_txd), .tx_send(o_send), .tx_parity(o_par),
    .tx_stop(o_stop), .busy(o_busy), .grant_id(o_gid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame occupies the line for FRAME clocks starting the cycle after the
  // grant decision; the first of those clocks carries the send strobe.
  int         m_left = 0;
  int         m_ptr  = NREQ-1;
  logic [7:0] m_data = 8'h00;
  logic       m_par  = 1'b0;
  bit         m_init = 1'b0;
  logic [3:0] v_pos  = 4'b0;
  int         waitc [NREQ];
  int         cyc    = 0;
  int         sel;
  bit         found;

  always @(posedge clk) begin
    cyc++;
    v_pos = req_valid;
    if (!rst_n) begin
      m_left = 0; m_ptr = NREQ-1; m_data = 8'h00; m_par = 1'b0; m_init = 1'b1;
      for (int i = 0; i < NREQ; i++) waitc[i] = 0;
    end else if (m_init) begin
      if (m_left > 0) begin
        m_left--;
      end else if (en && req_valid != 4'b0) begin
        found = 1'b0;
        sel   = 0;
        for (int k = 1; k <= NREQ; k++) begin
          if (!found && req_valid[(m_ptr + k) % NREQ]) begin
            found = 1'b1;
            sel   = (m_ptr + k) % NREQ;
          end
        end
        m_ptr  = sel;
        m_data = req_data[sel*8 +: 8];
        m_par  = ^m_data;
        m_left = FRAME;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic       e_send;
  logic [3:0] e_ready;

  always @(negedge clk) begin
    if (m_init) begin
      e_send  = (m_left == FRAME);
      e_ready = e_send ? (4'b1 << m_ptr) : 4'b0;
      chk("tx_send",   32'(tx_send),   32'(e_send));
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("busy",      32'(busy),      32'(m_left > 0));
      chk("grant_id",  32'(grant_id),  32'(m_ptr));
      chk("tx_stop",   32'(tx_stop),   32'd1);
      chk("tx_data",   32'(tx_data),   32'(m_data));
      chk("tx_parity", 32'(tx_parity), 32'(m_par));
      if (tx_send === 1'b1) begin
        for (int i = 0; i < NREQ; i++) begin
          if (i == int'(grant_id)) begin
            waitc[i] = 0;
          end else if (v_pos[i]) begin
            waitc[i]++;
            chk("fairness_within_nreq_minus_1", 32'(waitc[i] <= NREQ-1), 32'd1);
          end else begin
            waitc[i] = 0;
          end
        end
      end
    end
  end

  // ---------------- requesters ----------------
  // Hold valid and data until ready; in random mode raise new requests at random.
  bit rand_mode = 1'b0;

  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i] === 1'b1) begin
        req_valid[i] = 1'b0;
      end else if (rand_mode && !req_valid[i] && $urandom_range(0, 3) == 0) begin
        req_data[i*8 +: 8] = 8'($urandom);
        req_valid[i]       = 1'b1;
      end
    end
  end

  // ---------------- directed + random sequence ----------------
  task automatic wait_send(input string tag, input int maxc, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (tx_send !== 1'b1 && waited < maxc);
    chk({tag, "_send_seen"}, 32'(tx_send), 32'd1);
  endtask

  task automatic wait_odd_send(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_send !== 1'b1 && n < 30);
    chk({tag, "_send_seen"}, 32'(o_send), 32'd1);
  endtask

  int w, nb, nr, ns, last_cyc;

  initial begin
    rst_n = 1'b0; en = 1'b0; req_valid = 4'b0; req_data = 32'h0;
    o_en = 1'b0; o_valid = 4'b0; o_data = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_tx_send",   32'(tx_send),   32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_tx_stop",   32'(tx_stop),   32'd1);
    chk("rst_grant_id",  32'(grant_id),  32'd3);
    chk("rst_tx_data",   32'(tx_data),   32'd0);
    chk("rst_tx_parity", 32'(tx_parity), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request
    req_data[7:0] = 8'h41; req_valid = 4'b0001; en = 1'b1;
    wait_send("t1", 30, w);
    chk("t1_latency",   32'(w),         32'd1);
    chk("t1_tx_data",   32'(tx_data),   32'h41);
    chk("t1_tx_parity", 32'(tx_parity), 32'd0);
    chk("t1_req_ready", 32'(req_ready), 32'b0001);
    nb = 0; nr = 0;
    while (busy === 1'b1 && nb < 40) begin
      nb++;
      if (req_ready != 4'b0) nr++;
      @(negedge clk);
    end
    chk("t1_busy_cycles",  32'(nb), 32'd12);
    chk("t1_ready_cycles", 32'(nr), 32'd1);

    // Odd parity instance
    o_en = 1'b1;
    o_data[7:0] = 8'hA5; o_valid = 4'b0001;
    wait_odd_send("odd_a5");
    chk("odd_a5_parity", 32'(o_par), 32'd1);
    chk("odd_a5_data",   32'(o_txd), 32'hA5);
    o_valid = 4'b0;
    repeat (14) @(negedge clk);
    o_data[7:0] = 8'h07; o_valid = 4'b0001;
    wait_odd_send("odd_07");
    chk("odd_07_parity", 32'(o_par), 32'd0);
    o_valid = 4'b0;

    // All four requesters after reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; req_data = 32'h13121110; req_valid = 4'b1111;
    last_cyc = 0;
    for (int g = 0; g < 4; g++) begin
      wait_send($sformatf("t3_g%0d", g), 30, w);
      chk($sformatf("t3_grant%0d", g), 32'(grant_id), 32'(g));
      chk($sformatf("t3_data%0d", g),  32'(tx_data),  32'(8'h10 + g));
      if (g > 0) chk($sformatf("t3_spacing%0d", g), 32'(cyc - last_cyc), 32'd13);
      else       chk("t3_first_latency", 32'(w), 32'd1);
      last_cyc = cyc;
    end

    // Pointer fairness
    req_valid = 4'b0100;
    wait_send("t4_g2", 30, w);
    chk("t4_grant2", 32'(grant_id), 32'd2);
    @(negedge clk);
    req_valid = 4'b1010;
    wait_send("t4_g3", 30, w);
    chk("t4_grant3", 32'(grant_id), 32'd3);
    wait_send("t4_g1", 30, w);
    chk("t4_grant1", 32'(grant_id), 32'd1);

    // Reset in the middle of WAIT
    @(negedge clk);
    req_valid = 4'b0010;
    wait_send("t6_pre", 30, w);
    chk("t6_pre_grant", 32'(grant_id), 32'd1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0; req_valid = 4'b0011;
    @(negedge clk);
    chk("t6_busy",     32'(busy),      32'd0);
    chk("t6_tx_stop",  32'(tx_stop),   32'd1);
    chk("t6_grant_id", 32'(grant_id),  32'd3);
    chk("t6_tx_send",  32'(tx_send),   32'd0);
    chk("t6_ready",    32'(req_ready), 32'd0);
    rst_n = 1'b1;
    wait_send("t6_post", 30, w);
    chk("t6_post_latency", 32'(w),        32'd1);
    chk("t6_post_grant0",  32'(grant_id), 32'd0);
    wait_send("t6_next", 30, w);
    chk("t6_next_grant1",  32'(grant_id), 32'd1);
    repeat (15) @(negedge clk);

    // Enable gating
    en = 1'b0; req_data = 32'hC3B2A190; req_valid = 4'b1111;
    ns = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_send === 1'b1) ns++;
    end
    chk("t7_no_send_while_disabled", 32'(ns), 32'd0);
    en = 1'b1;
    wait_send("t7_enable", 30, w);
    chk("t7_enable_latency", 32'(w), 32'd1);
    repeat (60) @(negedge clk);
    chk("t7_all_drained", 32'(req_valid), 32'd0);

    // Randomized requesters, enable and occasional reset
    rand_mode = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      en    = ($urandom_range(0, 7) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
    end
    rand_mode = 1'b0; en = 1'b1; rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("final_drained", 32'(req_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter among NREQ byte requesters.
- Accepts one byte from the selected requester and computes its parity bit.
- Issues a single-cycle send strobe, with data, parity and stop bit, to the transmitter.
- Holds off the next grant until the transmitter has finished the frame, because the transmitter has no busy output.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; fixed to the transmitter bus width.
- FRAME_CYCLES, 12, clocks from transmitter accept until it is idle again. Covers idle sample, start, 8 data, parity and stop.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
- clk, in, 1, system clock; all logic on its rising edge.
- rst_n, in, 1, synchronous active-low reset.
- en, in, 1, arbitration enable; 0 blocks new grants.
- req_valid, in, NREQ, per-requester byte valid.
- req_data, in, NREQ*DATA_W, packed bytes; requester i at bits [i*DATA_W +: DATA_W].
- req_ready, out, NREQ, one-hot accept pulse; a transfer occurs when valid & ready are both high.
- tx_data, out, DATA_W, byte to the transmitter data input.
- tx_send, out, 1, one-cycle send strobe to the transmitter.
- tx_parity, out, 1, parity bit to the transmitter.
- tx_stop, out, 1, stop bit level; constant 1 after reset.
- busy, out, 1, high in SEND and WAIT.
- grant_id, out, clog2(NREQ), index of the last granted requester.

Behaviour:
- Reset values (rst_n = 0 at a clk edge):
  - state = IDLE; req_ready = 0; tx_send = 0; tx_data = 0; tx_parity = 0; tx_stop = 1; busy = 0; grant_id = NREQ-1.
  - With grant_id = NREQ-1 after reset, requester 0 has the highest priority first.
- FSM states: IDLE, SEND, WAIT.
- IDLE:
  - If en = 1 and any req_valid bit is set, select the first set bit searching from grant_id+1 upward, wrapping modulo NREQ.
  - Next cycle: state = SEND; tx_data = selected byte (registered); tx_parity = XOR of that byte, XOR PARITY_ODD; grant_id = selected index.
  - Otherwise remain in IDLE.
- SEND (exactly 1 cycle):
  - tx_send = 1 and req_ready[grant_id] = 1; all other ready bits are 0.
  - Counter loads FRAME_CYCLES-2; go to WAIT.
- WAIT:
  - tx_send = 0 and req_ready = 0; tx_data and tx_parity hold their values.
  - Counter decrements each cycle; when it reaches 0, go to IDLE.
  - Total SEND+WAIT time = FRAME_CYCLES cycles.
- Timing:
  - Latency from req_valid sampled in IDLE to tx_send = 1 cycle.
  - Minimum spacing between tx_send pulses = FRAME_CYCLES+1 clocks, because one IDLE cycle is always present.
- Requester rules:
  - A requester holds valid high and data stable until it sees ready.
  - The arbiter samples data only in the IDLE decision cycle.
  - A requester that drops valid before its ready pulse may still be transmitted, using the byte sampled in IDLE. This is a protocol violation and is not detected.
- Fairness: the pointer advances only on a grant. A requester that is continuously valid waits at most NREQ-1 frames.
- en = 0:
  - Only affects IDLE.
  - A frame in SEND or WAIT always completes.
- Reset mid-frame:
  - Forces IDLE immediately and drops tx_send and req_ready.
  - The transmitter may still finish its current frame.
  - After reset, software or the bench must wait FRAME_CYCLES before relying on line idle.
- Width rules:
  - Counter width = clog2(FRAME_CYCLES).
  - FRAME_CYCLES < 2 is illegal and is caught by an elaboration check.

Decomposition:
- Package uart_pkg:
  - State encoding localparams (IDLE, SEND, WAIT).
  - UART_DATA_W = 8.
  - UART_FRAME_CYCLES = 12.
  - Parity function (XOR reduce with an odd/even select).
- One sub-module, uart_rr_arbiter:
  - Combinational round-robin picker; inputs are the request vector and last grant; outputs are a one-hot grant plus its index.
  - Instantiated once in the IDLE decision path.

Test Plan:
- Single request: req_valid = 0001, data0 = 0x41, en = 1.
  - tx_send one cycle later with tx_data = 0x41 and tx_parity = 0 (even).
  - req_ready = 0001 for 1 cycle; busy high for 12 cycles.
- All four requests held valid with bytes 0x10..0x13 after reset.
  - Grants in order 0,1,2,3.
  - tx_send pulses exactly 13 clocks apart.
- Pointer fairness: after a grant to 2, req_valid = 1010.
  - Next grant is 3, then 1.
- Parity: PARITY_ODD = 1, byte 0xA5 (four ones) gives tx_parity = 1.
  - Byte 0x07 gives tx_parity = 0.
- Reset mid-WAIT: assert rst_n = 0 five cycles after tx_send.
  - Next edge: IDLE, busy = 0, tx_stop = 1, grant_id = 3.
  - With req 0 pending after release, it is granted first.
- en = 0 with req_valid = 1111:
  - No tx_send for 50 cycles.
  - Raise en: tx_send follows 1 cycle later.
